updown_counter_param: RTL and testbench

- Parametrised successor to the single-digit push-button up/down counter.
- Bounded up/down counter driven by two active-low push buttons.
- Adds input synchronisation, debounce, hold-to-auto-repeat, wrap/saturate mode, configurable range and step, synchronous load, and status flags.
- Sits between board buttons and display/LED logic; o_Cnt feeds the FND decoders.

---
 rtl/updown_counter_param.sv | 203 ++++++++++++++++++++
 tb/tb_updown_counter_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// Bounded up/down counter fed by two active-low push buttons, with per-button
// synchroniser and debounce, optional hold-to-repeat, synchronous load and status flags.
module updown_counter_param #(
   parameter int WIDTH        = 8,
   parameter int MIN_VAL      = 0,
   parameter int MAX_VAL      = 99,
   parameter int STEP         = 1,
   parameter int WRAP         = 1,
   parameter int DEBOUNCE_CYC = 4,
   parameter int REPEAT_DLY   = 0,
   parameter int REPEAT_PER   = 1
) (
   input  logic             i_Clk,
   input  logic             i_Rst,
   input  logic [1:0]       i_Push,
   input  logic             i_Load,
   input  logic [WIDTH-1:0] i_LoadVal,
   output logic [WIDTH-1:0] o_Cnt,
   output logic             o_AtMax,
   output logic             o_AtMin,
   output logic             o_Wrap
);

   localparam int DB_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int HOLD_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

   localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [HOLD_W-1:0] DLY_LAST = HOLD_W'(REPEAT_DLY - 1);
   localparam logic [HOLD_W-1:0] PER_LAST = HOLD_W'(REPEAT_PER - 1);

   // Bound arithmetic carries one spare bit so cnt+STEP never overflows.
   localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN_VAL);
   localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0]   DN_LIM = (WIDTH+1)'(MIN_VAL + STEP);
   localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

   logic [1:0]            sync1_q, sync2_q;
   logic [1:0]            deb_q, deb_d;
   logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic                  arm_q, arm_d;
   logic                  phase_q, phase_d;
   logic [HOLD_W-1:0]     hold_q, hold_d;
   logic                  up_step_q, up_step_d;
   logic                  dn_step_q, dn_step_d;
   logic [WIDTH-1:0]      cnt_q, cnt_d;
   logic                  wrap_q, wrap_d;

   logic [1:0]            fall_s;
   logic                  both_s, single_s;
   logic                  press_up_s, press_dn_s, press_any_s;
   logic                  rep_fire_s;
   logic [WIDTH:0]        cnt_x_s, up_x_s, load_x_s;
   logic                  load_lo_s, load_hi_s;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= i_Push;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: a level is accepted only after DEBOUNCE_CYC consecutive differing samples.
   always_comb begin
      deb_d    = deb_q;
      db_cnt_d = db_cnt_q;
      for (int b = 0; b < 2; b++) begin
         if (sync2_q[b] == deb_q[b]) begin
            db_cnt_d[b] = {DB_W{1'b0}};
         end else if (db_cnt_q[b] == DB_LAST) begin
            deb_d[b]    = sync2_q[b];
            db_cnt_d[b] = {DB_W{1'b0}};
         end else begin
            db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
         end
      end
   end

   always_comb begin
      fall_s      = deb_q & ~deb_d;
      both_s      = (deb_d == 2'b00);
      single_s    = ^deb_d;
      press_up_s  = fall_s[1] & ~both_s;
      press_dn_s  = fall_s[0] & ~both_s;
      press_any_s = press_up_s | press_dn_s;
   end

   // Hold timer only runs after a clean single press; a two-button chord disarms it.
   always_comb begin
      arm_d      = arm_q;
      phase_d    = phase_q;
      hold_d     = hold_q;
      rep_fire_s = 1'b0;
      if (REPEAT_DLY == 0) begin
         arm_d   = 1'b0;
         phase_d = 1'b0;
         hold_d  = {HOLD_W{1'b0}};
      end else if (press_any_s) begin
         arm_d   = 1'b1;
         phase_d = 1'b0;
         hold_d  = {HOLD_W{1'b0}};
      end else if (!single_s || !arm_q) begin
         arm_d   = 1'b0;
         phase_d = 1'b0;
         hold_d  = {HOLD_W{1'b0}};
      end else if (hold_q == (phase_q ? PER_LAST : DLY_LAST)) begin
         rep_fire_s = 1'b1;
         phase_d    = 1'b1;
         hold_d     = {HOLD_W{1'b0}};
      end else begin
         hold_d = hold_q + HOLD_W'(1);
      end
   end

   always_comb begin
      up_step_d = press_up_s | (rep_fire_s & ~deb_d[1]);
      dn_step_d = press_dn_s | (rep_fire_s & ~deb_d[0]);
   end

   always_comb begin
      cnt_x_s  = {1'b0, cnt_q};
      up_x_s   = cnt_x_s + STEP_X;
      load_x_s = {1'b0, i_LoadVal};
      load_hi_s = (load_x_s > MAX_X);
   end

   if (MIN_VAL > 0) begin : g_load_lo
      assign load_lo_s = (load_x_s < MIN_X);
   end else begin : g_no_load_lo
      assign load_lo_s = 1'b0;
   end

   // Load wins over any step pulse landing in the same cycle.
   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (i_Load) begin
         if (load_lo_s) begin
            cnt_d = MIN_V;
         end else if (load_hi_s) begin
            cnt_d = MAX_V;
         end else begin
            cnt_d = i_LoadVal;
         end
      end else if (up_step_q) begin
         if (up_x_s <= MAX_X) begin
            cnt_d = up_x_s[WIDTH-1:0];
         end else if (WRAP != 0) begin
            cnt_d  = MIN_V;
            wrap_d = 1'b1;
         end else begin
            cnt_d = MAX_V;
         end
      end else if (dn_step_q) begin
         if (cnt_x_s >= DN_LIM) begin
            cnt_d = cnt_q - STEP_V;
         end else if (WRAP != 0) begin
            cnt_d  = MAX_V;
            wrap_d = 1'b1;
         end else begin
            cnt_d = MIN_V;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         deb_q     <= 2'b11;
         db_cnt_q  <= {2{ {DB_W{1'b0}} }};
         arm_q     <= 1'b0;
         phase_q   <= 1'b0;
         hold_q    <= {HOLD_W{1'b0}};
         up_step_q <= 1'b0;
         dn_step_q <= 1'b0;
         cnt_q     <= MIN_V;
         wrap_q    <= 1'b0;
      end else begin
         deb_q     <= deb_d;
         db_cnt_q  <= db_cnt_d;
         arm_q     <= arm_d;
         phase_q   <= phase_d;
         hold_q    <= hold_d;
         up_step_q <= up_step_d;
         dn_step_q <= dn_step_d;
         cnt_q     <= cnt_d;
         wrap_q    <= wrap_d;
      end
   end

   assign o_Cnt   = cnt_q;
   assign o_Wrap  = wrap_q;
   assign o_AtMax = (cnt_q == MAX_V);
   assign o_AtMin = (cnt_q == MIN_V);

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench: four counter instances (wrap, saturate, step-4, auto-repeat)
// sharing one clock and reset, each checked against hand-computed values.
module tb_updown_counter_param;

   logic       clk;
   logic       rst;
   logic [1:0] push   [4];
   logic       ld     [4];
   logic [3:0] ldv    [4];
   logic [3:0] cnt    [4];
   logic       atmax  [4];
   logic       atmin  [4];
   logic       wrp    [4];
   int         wraps  [4];
   int         errs;
   int         checks;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   updown_counter_param #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .STEP(1), .WRAP(1),
      .DEBOUNCE_CYC(4), .REPEAT_DLY(0), .REPEAT_PER(1)) u_wrap (
      .i_Clk(clk), .i_Rst(rst), .i_Push(push[0]), .i_Load(ld[0]), .i_LoadVal(ldv[0]),
      .o_Cnt(cnt[0]), .o_AtMax(atmax[0]), .o_AtMin(atmin[0]), .o_Wrap(wrp[0]));

   updown_counter_param #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .STEP(1), .WRAP(0),
      .DEBOUNCE_CYC(4), .REPEAT_DLY(0), .REPEAT_PER(1)) u_sat (
      .i_Clk(clk), .i_Rst(rst), .i_Push(push[1]), .i_Load(ld[1]), .i_LoadVal(ldv[1]),
      .o_Cnt(cnt[1]), .o_AtMax(atmax[1]), .o_AtMin(atmin[1]), .o_Wrap(wrp[1]));

   updown_counter_param #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .STEP(4), .WRAP(0),
      .DEBOUNCE_CYC(4), .REPEAT_DLY(0), .REPEAT_PER(1)) u_step4 (
      .i_Clk(clk), .i_Rst(rst), .i_Push(push[2]), .i_Load(ld[2]), .i_LoadVal(ldv[2]),
      .o_Cnt(cnt[2]), .o_AtMax(atmax[2]), .o_AtMin(atmin[2]), .o_Wrap(wrp[2]));

   updown_counter_param #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .STEP(1), .WRAP(1),
      .DEBOUNCE_CYC(4), .REPEAT_DLY(20), .REPEAT_PER(5)) u_rep (
      .i_Clk(clk), .i_Rst(rst), .i_Push(push[3]), .i_Load(ld[3]), .i_LoadVal(ldv[3]),
      .o_Cnt(cnt[3]), .o_AtMax(atmax[3]), .o_AtMin(atmin[3]), .o_Wrap(wrp[3]));

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) wraps[i] = wraps[i] + int'(wrp[i]);
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks = checks + 1;
      if (got !== exp) begin
         errs = errs + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int idx, input logic [1:0] lvl, input int hold);
      push[idx] = lvl;
      tick(hold);
      push[idx] = 2'b11;
      tick(12);
   endtask

   task automatic load(input int idx, input logic [3:0] val);
      ld[idx]  = 1'b1;
      ldv[idx] = val;
      tick(1);
      ld[idx]  = 1'b0;
      tick(1);
   endtask

   initial begin
      errs   = 0;
      checks = 0;
      for (int i = 0; i < 4; i++) begin
         push[i]  = 2'b11;
         ld[i]    = 1'b0;
         ldv[i]   = 4'd0;
         wraps[i] = 0;
      end
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(2);

      chk("rst_cnt", int'(cnt[0]), 0);
      chk("rst_atmin", int'(atmin[0]), 1);
      chk("rst_atmax", int'(atmax[0]), 0);
      chk("rst_wrap", wraps[0], 0);
      chk("rst_cnt_rep", int'(cnt[3]), 0);

      // Press latency: the count must move exactly six edges after the first low sample.
      push[0] = 2'b01;
      tick(6);
      chk("lat_k5", int'(cnt[0]), 0);
      tick(1);
      chk("lat_k6", int'(cnt[0]), 1);
      chk("lat_atmin", int'(atmin[0]), 0);
      tick(2);
      push[0] = 2'b11;
      tick(12);
      chk("release_nostep", int'(cnt[0]), 1);

      press(0, 2'b01, 3);
      chk("glitch3", int'(cnt[0]), 1);
      press(0, 2'b01, 4);
      chk("glitch4", int'(cnt[0]), 2);

      load(0, 4'd9);
      chk("load9", int'(cnt[0]), 9);
      chk("load9_atmax", int'(atmax[0]), 1);
      press(0, 2'b01, 8);
      chk("wrap_up_cnt", int'(cnt[0]), 0);
      chk("wrap_up_pulse", wraps[0], 1);
      press(0, 2'b10, 8);
      chk("wrap_dn_cnt", int'(cnt[0]), 9);
      chk("wrap_dn_pulse", wraps[0], 2);

      load(0, 4'd5);
      chk("load5", int'(cnt[0]), 5);
      push[0] = 2'b01;
      tick(6);
      ld[0]  = 1'b1;
      ldv[0] = 4'd15;
      tick(1);
      ld[0]  = 1'b0;
      chk("load_clamp", int'(cnt[0]), 9);
      tick(2);
      push[0] = 2'b11;
      tick(12);
      chk("load_step_dropped", int'(cnt[0]), 9);
      chk("load_no_wrap", wraps[0], 2);

      load(0, 4'd3);
      push[0] = 2'b00;
      tick(10);
      chk("both_hold", int'(cnt[0]), 3);
      push[0] = 2'b10;
      tick(12);
      chk("both_rel_one", int'(cnt[0]), 3);
      push[0] = 2'b11;
      tick(12);
      chk("both_rel_all", int'(cnt[0]), 3);

      load(1, 4'd9);
      press(1, 2'b01, 8);
      chk("sat_up", int'(cnt[1]), 9);
      load(1, 4'd0);
      press(1, 2'b10, 8);
      chk("sat_dn", int'(cnt[1]), 0);
      chk("sat_atmin", int'(atmin[1]), 1);
      chk("sat_no_wrap", wraps[1], 0);

      load(2, 4'd7);
      press(2, 2'b01, 8);
      chk("step4_up_sat", int'(cnt[2]), 9);
      load(2, 4'd2);
      press(2, 2'b10, 8);
      chk("step4_dn_sat", int'(cnt[2]), 0);
      press(2, 2'b01, 8);
      chk("step4_up", int'(cnt[2]), 4);

      // Auto-repeat: steps at press+0, +20, +25, +30, +35, +40.
      push[3] = 2'b01;
      tick(7);
      chk("rep_press", int'(cnt[3]), 1);
      tick(19);
      chk("rep_p19", int'(cnt[3]), 1);
      tick(1);
      chk("rep_p20", int'(cnt[3]), 2);
      tick(4);
      chk("rep_p24", int'(cnt[3]), 2);
      tick(1);
      chk("rep_p25", int'(cnt[3]), 3);
      tick(15);
      chk("rep_p40", int'(cnt[3]), 6);

      rst = 1'b1;
      #1;
      chk("rst_async_cnt", int'(cnt[3]), 0);
      chk("rst_async_atmin", int'(atmin[3]), 1);
      @(negedge clk);
      rst = 1'b0;
      tick(6);
      chk("repress_k5", int'(cnt[3]), 0);
      tick(1);
      chk("repress_k6", int'(cnt[3]), 1);
      push[3] = 2'b11;
      tick(12);
      chk("repress_final", int'(cnt[3]), 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
